bsg_axil_rr_arbiter: RTL and testbench
======================================

# bsg_axil_rr_arbiter

Round-robin arbiter that shares one AXI4-Lite slave port among `num_masters_p` AXI4-Lite masters, e.g. several cosim DPI drivers or accelerator clients contending for one GP/HP port of the shell. The arbiter allows one transaction in flight at a time, so bus ordering is total and responses need no ID routing. It sits between the masters and the shared port, on the same `aclk` domain.

## Interface
- `num_masters_p`, 2: number of upstream masters (≥2).
- `addr_width_p`, 32: AXI-Lite address width.
- `data_width_p`, 32: AXI-Lite data width. Strobe width is `data_width_p/8`.
- `aclk_i`, in, 1: clock.
- `aresetn_i`, in, 1: reset. One clock; reset is asynchronous and active-low.
- `s_aw{addr,prot,valid}_i` / `s_awready_o`, in/out, `[num_masters_p]` × {addr_width_p, 3, 1} / `[num_masters_p]`: per-master write address channel.
- `s_w{data,strb,valid}_i` / `s_wready_o`, in/out, `[num_masters_p]` × {data_width_p, data_width_p/8, 1} / `[num_masters_p]`: per-master write data channel.
- `s_b{resp,valid}_o` / `s_bready_i`, out/in, `[num_masters_p]` × {2, 1} / `[num_masters_p]`: per-master write response channel.
- `s_ar{addr,prot,valid}_i` / `s_arready_o`, in/out, `[num_masters_p]` × {addr_width_p, 3, 1} / `[num_masters_p]`: per-master read address channel.
- `s_r{data,resp,valid}_o` / `s_rready_i`, out/in, `[num_masters_p]` × {data_width_p, 2, 1} / `[num_masters_p]`: per-master read data channel.
- `m_*`, mirrored directions, single port: the shared downstream AXI-Lite port.
- `grant_id_o`, out, `$clog2(num_masters_p)`: index of the current owner. Valid when `busy_o` is high.
- `busy_o`, out, 1: a transaction is in flight.

## Operation
- Master i requests when `s_awvalid[i] | s_arvalid[i]`. If the same master requests both, write goes first.
- States:
  - IDLE: if any request is present, register the round-robin winner into `grant_id`, latch the direction, then go to WADDR or RADDR.
  - WADDR: forward the granted master's AW and W to `m_*`, gated by the `aw_done` and `w_done` flags. `m_awvalid = s_awvalid[g] & ~aw_done`; W is gated the same way. A channel's flag sets on its downstream handshake. When both flags are set (including the same cycle), go to WRESP.
  - WRESP: `s_bvalid[g] = m_bvalid` and `m_bready = s_bready[g]`. On the handshake, clear the flags, advance the pointer, go to IDLE.
  - RADDR: forward AR. On `m_arready & m_arvalid`, go to RRESP.
  - RRESP: route R to master g. On the handshake, advance the pointer, go to IDLE.
- Round-robin: on completion the pointer becomes `g+1` mod `num_masters_p`. The search starts at the pointer.
- Non-granted masters see every `ready` and `valid` output at 0.
- Payload to `m_*` is a mux on `grant_id`. Response data fans out to all masters; only `valid` is gated.
- Dropping `valid` before handshake is an AXI violation. It is flagged by a nonsynth assertion, not handled.

## Timing
- Reset values (asynchronous): state IDLE, pointer 0, flags 0, `busy_o` 0, `grant_id_o` 0, all `valid`/`ready` outputs 0.
- Arbitration is registered: a request seen in IDLE at cycle N is forwarded downstream in cycle N+1. There is no combinational path from `s_*valid` to `m_*valid` across the grant decision.
- Within a granted transaction, forwarding is combinational, so a zero-wait slave costs 0 extra cycles per channel.
- Minimum occupancy: read 3 cycles (IDLE, RADDR, RRESP); write 3 cycles (AW and W in the same cycle).
- Back-to-back transactions: one IDLE cycle between them.
- `aresetn_i` deasserted mid-transaction: state returns to IDLE immediately. The downstream slave shares the reset, so no orphaned responses are tolerated.

## Structure
- `bsg_axil_rr_arbiter_pkg` holds the state enum (`e_idle`, `e_waddr`, `e_wresp`, `e_raddr`, `e_rresp`) and the AXI-Lite resp constants (`OKAY=2'b00`, `SLVERR=2'b10`).
- Sub-module `bsg_axil_rr_pick`: a combinational round-robin priority encoder. Inputs are the request vector and the pointer; outputs are the winner index and `v_o`.
- The top level holds the FSM, pointer, flags and muxes.

## Test plan
- Single write from master 1: addr 0x10, data 0xDEADBEEF, zero-wait slave. Expect slave AW and W in cycle 1, `s_bvalid[1]` high in cycle 2, `grant_id_o`=1, master 0 untouched.
- All masters issue reads at once (N=4, pointer 0). Expect service order 0,1,2,3, each shown by `grant_id_o`. Then master 0 re-requests while master 2 is requesting with the pointer at 0: master 0 wins first.
- Slave accepts W three cycles before AW. Expect W not re-presented (`w_done` held), then WRESP after AW.
- Master 0 presents both AW/W and AR. Expect the write completes first, then the read (after other pending masters per round-robin).
- Slave stalls `rvalid` 10 cycles while master 1 requests. Expect master 1 to get no `arready` until master 0's R handshake plus one cycle.
- Assert reset during WRESP. Expect all outputs 0 the same cycle and IDLE afterwards. The next request is granted from pointer 0.

Source files
------------

// File: rtl/bsg_axil_rr_arbiter_pkg.sv
// bsg_axil_rr_arbiter_pkg
//   Shared types and constants for the AXI4-Lite round-robin arbiter:
//   the arbiter FSM state encoding, AXI-Lite response codes and the
//   round-robin pointer advance helper.
package bsg_axil_rr_arbiter_pkg;

  typedef enum logic [2:0] {
    e_idle,
    e_waddr,
    e_wresp,
    e_raddr,
    e_rresp
  } state_e;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  // Pointer value after master g completes: g+1 wrapping at n.
  function automatic int unsigned rr_next(input int unsigned g, input int unsigned n);
    return (g + 1 >= n) ? 0 : g + 1;
  endfunction

endpackage

// File: rtl/bsg_axil_rr_arbiter_pick.sv
// bsg_axil_rr_pick
//   Combinational round-robin priority encoder. The search starts at
//   ptr_i and wraps; the first set request bit wins.
//   req_i : request vector, one bit per master
//   ptr_i : index with highest priority this round
//   id_o  : winning index (0 when v_o is low)
//   v_o   : at least one request present
module bsg_axil_rr_pick
  import bsg_axil_rr_arbiter_pkg::*;
#(
  parameter int unsigned num_p  = 2,
  parameter int unsigned id_w_p = 1
) (
  input  logic [num_p-1:0]  req_i,
  input  logic [id_w_p-1:0] ptr_i,
  output logic [id_w_p-1:0] id_o,
  output logic              v_o
);

  int unsigned idx;

  // Scan from lowest to highest priority so the last hit (ptr_i itself
  // when requesting) overrides earlier ones.
  always_comb begin
    v_o  = 1'b0;
    id_o = '0;
    idx  = 0;
    for (int unsigned k = 0; k < num_p; k++) begin
      idx = (32'(ptr_i) + (num_p - 1 - k)) % num_p;
      if (req_i[idx[id_w_p-1:0]]) begin
        v_o  = 1'b1;
        id_o = idx[id_w_p-1:0];
      end
    end
  end

endmodule

// File: rtl/bsg_axil_rr_arbiter.sv
// bsg_axil_rr_arbiter
//   Shares one AXI4-Lite slave port among num_masters_p AXI4-Lite masters
//   with one transaction in flight at a time, granted round-robin.
//   aclk_i / aresetn_i : clock, asynchronous active-low reset
//   s_aw*, s_w*, s_b*, s_ar*, s_r* : per-master upstream channels (packed
//                                    [num_masters_p] arrays)
//   m_*                 : shared downstream port
//   grant_id_o          : current owner, meaningful while busy_o is high
//   busy_o              : a transaction is in flight
module bsg_axil_rr_arbiter
  import bsg_axil_rr_arbiter_pkg::*;
#(
  parameter int unsigned num_masters_p = 2,
  parameter int unsigned addr_width_p  = 32,
  parameter int unsigned data_width_p  = 32,
  localparam int unsigned gw_lp        = $clog2(num_masters_p),
  localparam int unsigned strb_w_lp    = data_width_p / 8
) (
  input  logic                                         aclk_i,
  input  logic                                         aresetn_i,

  input  logic [num_masters_p-1:0][addr_width_p-1:0]   s_awaddr_i,
  input  logic [num_masters_p-1:0][2:0]                s_awprot_i,
  input  logic [num_masters_p-1:0]                     s_awvalid_i,
  output logic [num_masters_p-1:0]                     s_awready_o,

  input  logic [num_masters_p-1:0][data_width_p-1:0]   s_wdata_i,
  input  logic [num_masters_p-1:0][strb_w_lp-1:0]      s_wstrb_i,
  input  logic [num_masters_p-1:0]                     s_wvalid_i,
  output logic [num_masters_p-1:0]                     s_wready_o,

  output logic [num_masters_p-1:0][1:0]                s_bresp_o,
  output logic [num_masters_p-1:0]                     s_bvalid_o,
  input  logic [num_masters_p-1:0]                     s_bready_i,

  input  logic [num_masters_p-1:0][addr_width_p-1:0]   s_araddr_i,
  input  logic [num_masters_p-1:0][2:0]                s_arprot_i,
  input  logic [num_masters_p-1:0]                     s_arvalid_i,
  output logic [num_masters_p-1:0]                     s_arready_o,

  output logic [num_masters_p-1:0][data_width_p-1:0]   s_rdata_o,
  output logic [num_masters_p-1:0][1:0]                s_rresp_o,
  output logic [num_masters_p-1:0]                     s_rvalid_o,
  input  logic [num_masters_p-1:0]                     s_rready_i,

  output logic [addr_width_p-1:0]                      m_awaddr_o,
  output logic [2:0]                                   m_awprot_o,
  output logic                                         m_awvalid_o,
  input  logic                                         m_awready_i,

  output logic [data_width_p-1:0]                      m_wdata_o,
  output logic [strb_w_lp-1:0]                         m_wstrb_o,
  output logic                                         m_wvalid_o,
  input  logic                                         m_wready_i,

  input  logic [1:0]                                   m_bresp_i,
  input  logic                                         m_bvalid_i,
  output logic                                         m_bready_o,

  output logic [addr_width_p-1:0]                      m_araddr_o,
  output logic [2:0]                                   m_arprot_o,
  output logic                                         m_arvalid_o,
  input  logic                                         m_arready_i,

  input  logic [data_width_p-1:0]                      m_rdata_i,
  input  logic [1:0]                                   m_rresp_i,
  input  logic                                         m_rvalid_i,
  output logic                                         m_rready_o,

  output logic [gw_lp-1:0]                             grant_id_o,
  output logic                                         busy_o
);

  state_e             state_q, state_d;
  logic [gw_lp-1:0]   grant_q, grant_d;
  logic [gw_lp-1:0]   ptr_q, ptr_d;
  logic               aw_done_q, aw_done_d;
  logic               w_done_q, w_done_d;

  logic [gw_lp-1:0]   pick_id;
  logic               pick_v;

  bsg_axil_rr_pick #(
    .num_p  (num_masters_p),
    .id_w_p (gw_lp)
  ) u_pick (
    .req_i (s_awvalid_i | s_arvalid_i),
    .ptr_i (ptr_q),
    .id_o  (pick_id),
    .v_o   (pick_v)
  );

  // Request payloads are muxed by the registered grant; response payloads
  // fan out to everyone and only the valids are steered.
  assign m_awaddr_o = s_awaddr_i[grant_q];
  assign m_awprot_o = s_awprot_i[grant_q];
  assign m_wdata_o  = s_wdata_i[grant_q];
  assign m_wstrb_o  = s_wstrb_i[grant_q];
  assign m_araddr_o = s_araddr_i[grant_q];
  assign m_arprot_o = s_arprot_i[grant_q];

  assign s_bresp_o  = {num_masters_p{m_bresp_i}};
  assign s_rdata_o  = {num_masters_p{m_rdata_i}};
  assign s_rresp_o  = {num_masters_p{m_rresp_i}};

  assign grant_id_o = grant_q;
  assign busy_o     = (state_q != e_idle);

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    s_awready_o = '0;
    s_wready_o  = '0;
    s_bvalid_o  = '0;
    s_arready_o = '0;
    s_rvalid_o  = '0;
    m_awvalid_o = 1'b0;
    m_wvalid_o  = 1'b0;
    m_bready_o  = 1'b0;
    m_arvalid_o = 1'b0;
    m_rready_o  = 1'b0;

    unique case (state_q)
      e_idle: begin
        // Grant is registered here; nothing is forwarded until next cycle.
        if (pick_v) begin
          grant_d = pick_id;
          state_d = s_awvalid_i[pick_id] ? e_waddr : e_raddr;
        end
      end

      e_waddr: begin
        // AW and W complete independently; each is masked once accepted.
        m_awvalid_o             = s_awvalid_i[grant_q] & ~aw_done_q;
        s_awready_o[grant_q]    = m_awready_i & ~aw_done_q;
        m_wvalid_o              = s_wvalid_i[grant_q] & ~w_done_q;
        s_wready_o[grant_q]     = m_wready_i & ~w_done_q;
        aw_done_d               = aw_done_q | (m_awvalid_o & m_awready_i);
        w_done_d                = w_done_q | (m_wvalid_o & m_wready_i);
        if (aw_done_d && w_done_d) state_d = e_wresp;
      end

      e_wresp: begin
        s_bvalid_o[grant_q] = m_bvalid_i;
        m_bready_o          = s_bready_i[grant_q];
        if (m_bvalid_i && m_bready_o) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          ptr_d     = gw_lp'(rr_next(32'(grant_q), num_masters_p));
          state_d   = e_idle;
        end
      end

      e_raddr: begin
        m_arvalid_o          = s_arvalid_i[grant_q];
        s_arready_o[grant_q] = m_arready_i;
        if (m_arvalid_o && m_arready_i) state_d = e_rresp;
      end

      e_rresp: begin
        s_rvalid_o[grant_q] = m_rvalid_i;
        m_rready_o          = s_rready_i[grant_q];
        if (m_rvalid_i && m_rready_o) begin
          ptr_d   = gw_lp'(rr_next(32'(grant_q), num_masters_p));
          state_d = e_idle;
        end
      end

      default: state_d = e_idle;
    endcase
  end

  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      state_q   <= e_idle;
      grant_q   <= '0;
      ptr_q     <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

`ifndef SYNTHESIS
  // Masters must hold valid until accepted; the arbiter does not recover.
  property p_hold(logic v, logic r);
    @(posedge aclk_i) disable iff (!aresetn_i) (v && !r) |=> v;
  endproperty

  a_aw_hold: assert property (p_hold(m_awvalid_o, m_awready_i))
    else $error("awvalid dropped before handshake");
  a_w_hold:  assert property (p_hold(m_wvalid_o, m_wready_i))
    else $error("wvalid dropped before handshake");
  a_ar_hold: assert property (p_hold(m_arvalid_o, m_arready_i))
    else $error("arvalid dropped before handshake");
`endif

endmodule

// File: tb/tb_bsg_axil_rr_arbiter.sv
// tb_bsg_axil_rr_arbiter
//   Directed bench for the AXI4-Lite round-robin arbiter with four masters.
//   The bench plays both the masters and the shared slave.
module tb_bsg_axil_rr_arbiter;
  import bsg_axil_rr_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int GW = 2;

  logic clk = 1'b0;
  logic aresetn;

  logic [N-1:0][AW-1:0]   s_awaddr;
  logic [N-1:0][2:0]      s_awprot;
  logic [N-1:0]           s_awvalid, s_awready;
  logic [N-1:0][DW-1:0]   s_wdata;
  logic [N-1:0][DW/8-1:0] s_wstrb;
  logic [N-1:0]           s_wvalid, s_wready;
  logic [N-1:0][1:0]      s_bresp;
  logic [N-1:0]           s_bvalid, s_bready;
  logic [N-1:0][AW-1:0]   s_araddr;
  logic [N-1:0][2:0]      s_arprot;
  logic [N-1:0]           s_arvalid, s_arready;
  logic [N-1:0][DW-1:0]   s_rdata;
  logic [N-1:0][1:0]      s_rresp;
  logic [N-1:0]           s_rvalid, s_rready;

  logic [AW-1:0]   m_awaddr, m_araddr;
  logic [2:0]      m_awprot, m_arprot;
  logic            m_awvalid, m_awready, m_wvalid, m_wready;
  logic [DW-1:0]   m_wdata, m_rdata;
  logic [DW/8-1:0] m_wstrb;
  logic [1:0]      m_bresp, m_rresp;
  logic            m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready;
  logic [GW-1:0]   grant_id;
  logic            busy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  bsg_axil_rr_arbiter #(
    .num_masters_p (N),
    .addr_width_p  (AW),
    .data_width_p  (DW)
  ) dut (
    .aclk_i      (clk),
    .aresetn_i   (aresetn),
    .s_awaddr_i  (s_awaddr),
    .s_awprot_i  (s_awprot),
    .s_awvalid_i (s_awvalid),
    .s_awready_o (s_awready),
    .s_wdata_i   (s_wdata),
    .s_wstrb_i   (s_wstrb),
    .s_wvalid_i  (s_wvalid),
    .s_wready_o  (s_wready),
    .s_bresp_o   (s_bresp),
    .s_bvalid_o  (s_bvalid),
    .s_bready_i  (s_bready),
    .s_araddr_i  (s_araddr),
    .s_arprot_i  (s_arprot),
    .s_arvalid_i (s_arvalid),
    .s_arready_o (s_arready),
    .s_rdata_o   (s_rdata),
    .s_rresp_o   (s_rresp),
    .s_rvalid_o  (s_rvalid),
    .s_rready_i  (s_rready),
    .m_awaddr_o  (m_awaddr),
    .m_awprot_o  (m_awprot),
    .m_awvalid_o (m_awvalid),
    .m_awready_i (m_awready),
    .m_wdata_o   (m_wdata),
    .m_wstrb_o   (m_wstrb),
    .m_wvalid_o  (m_wvalid),
    .m_wready_i  (m_wready),
    .m_bresp_i   (m_bresp),
    .m_bvalid_i  (m_bvalid),
    .m_bready_o  (m_bready),
    .m_araddr_o  (m_araddr),
    .m_arprot_o  (m_arprot),
    .m_arvalid_o (m_arvalid),
    .m_arready_i (m_arready),
    .m_rdata_i   (m_rdata),
    .m_rresp_i   (m_rresp),
    .m_rvalid_i  (m_rvalid),
    .m_rready_o  (m_rready),
    .grant_id_o  (grant_id),
    .busy_o      (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Request for master m must already be raised in an IDLE cycle.
  task automatic rd_txn(input int m, input logic [31:0] addr, input logic [31:0] data);
    tick();
    chk("rd_grant", 64'(grant_id), 64'(m));
    chk("rd_m_arvalid", 64'(m_arvalid), 64'd1);
    chk("rd_m_araddr", 64'(m_araddr), 64'(addr));
    chk("rd_s_arready", 64'(s_arready), 64'd1 << m);
    tick();
    s_arvalid[m] = 1'b0;
    m_rvalid = 1'b1;
    m_rdata  = data;
    m_rresp  = OKAY;
    #1;
    chk("rd_s_rvalid", 64'(s_rvalid), 64'd1 << m);
    chk("rd_s_rdata", 64'(s_rdata[m]), 64'(data));
    chk("rd_m_rready", 64'(m_rready), 64'd1);
    tick();
    m_rvalid = 1'b0;
    #1;
    chk("rd_idle", 64'(busy), 64'd0);
  endtask

  // Zero-wait write; AW/W of master m must already be raised in IDLE.
  task automatic wr_txn(input int m, input logic [31:0] addr, input logic [31:0] data);
    tick();
    chk("wr_grant", 64'(grant_id), 64'(m));
    chk("wr_busy", 64'(busy), 64'd1);
    chk("wr_m_awvalid", 64'(m_awvalid), 64'd1);
    chk("wr_m_wvalid", 64'(m_wvalid), 64'd1);
    chk("wr_m_awaddr", 64'(m_awaddr), 64'(addr));
    chk("wr_m_wdata", 64'(m_wdata), 64'(data));
    chk("wr_m_wstrb", 64'(m_wstrb), 64'hF);
    chk("wr_s_awready", 64'(s_awready), 64'd1 << m);
    chk("wr_s_wready", 64'(s_wready), 64'd1 << m);
    chk("wr_m_arvalid", 64'(m_arvalid), 64'd0);
    tick();
    s_awvalid[m] = 1'b0;
    s_wvalid[m]  = 1'b0;
    m_bvalid = 1'b1;
    m_bresp  = OKAY;
    #1;
    chk("wr_s_bvalid", 64'(s_bvalid), 64'd1 << m);
    chk("wr_m_bready", 64'(m_bready), 64'd1);
    chk("wr_m_awvalid_off", 64'(m_awvalid), 64'd0);
    tick();
    m_bvalid = 1'b0;
    #1;
    chk("wr_idle", 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
    $fatal(1, "timeout");
  end

  initial begin
    aresetn   = 1'b1;
    s_awaddr  = '0; s_awprot = '0; s_awvalid = '0;
    s_wdata   = '0; s_wstrb  = '1; s_wvalid  = '0;
    s_bready  = '1;
    s_araddr  = '0; s_arprot = '0; s_arvalid = '0;
    s_rready  = '1;
    m_awready = 1'b1; m_wready = 1'b1; m_arready = 1'b1;
    m_bvalid  = 1'b0; m_bresp  = OKAY;
    m_rvalid  = 1'b0; m_rresp  = OKAY; m_rdata = '0;

    // Reset state
    #2 aresetn = 1'b0;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_grant", 64'(grant_id), 64'd0);
    chk("rst_m_valids", 64'({m_awvalid, m_wvalid, m_arvalid}), 64'd0);
    chk("rst_m_readys", 64'({m_bready, m_rready}), 64'd0);
    chk("rst_s_readys", 64'({s_awready, s_wready, s_arready}), 64'd0);
    chk("rst_s_valids", 64'({s_bvalid, s_rvalid}), 64'd0);
    tick();
    tick();
    aresetn = 1'b1;

    // All four masters read at once: served 0,1,2,3
    for (int i = 0; i < N; i++) begin
      s_arvalid[i] = 1'b1;
      s_araddr[i]  = 32'h100 + 32'(i);
    end
    #1;
    chk("rr_idle_no_fwd", 64'(m_arvalid), 64'd0);
    for (int i = 0; i < N; i++) rd_txn(i, 32'h100 + 32'(i), 32'hA0 + 32'(i));

    // Pointer back at 0: master 0 beats master 2
    s_arvalid[0] = 1'b1; s_araddr[0] = 32'h200;
    s_arvalid[2] = 1'b1; s_araddr[2] = 32'h208;
    rd_txn(0, 32'h200, 32'h11);
    rd_txn(2, 32'h208, 32'h22);

    // Single write from master 1
    s_awvalid[1] = 1'b1; s_awaddr[1] = 32'h10;
    s_wvalid[1]  = 1'b1; s_wdata[1]  = 32'hDEADBEEF;
    #1;
    chk("w1_idle_no_fwd", 64'({m_awvalid, m_wvalid}), 64'd0);
    chk("w1_idle_busy", 64'(busy), 64'd0);
    wr_txn(1, 32'h10, 32'hDEADBEEF);

    // Slave takes W three cycles before AW (master 2)
    s_awvalid[2] = 1'b1; s_awaddr[2] = 32'h20;
    s_wvalid[2]  = 1'b1; s_wdata[2]  = 32'h12345678;
    m_awready = 1'b0;
    tick();
    chk("wa_grant", 64'(grant_id), 64'd2);
    chk("wa_m_wvalid", 64'(m_wvalid), 64'd1);
    chk("wa_s_wready", 64'(s_wready), 64'b0100);
    chk("wa_s_awready", 64'(s_awready), 64'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("wa_w_held", 64'(m_wvalid), 64'd0);
      chk("wa_s_wready_off", 64'(s_wready), 64'd0);
      chk("wa_m_awvalid", 64'(m_awvalid), 64'd1);
    end
    tick();
    m_awready = 1'b1;
    #1;
    chk("wa_s_awready_on", 64'(s_awready), 64'b0100);
    chk("wa_still_no_w", 64'(m_wvalid), 64'd0);
    tick();
    s_awvalid[2] = 1'b0; s_wvalid[2] = 1'b0;
    m_bvalid = 1'b1; m_bresp = SLVERR;
    #1;
    chk("wa_s_bvalid", 64'(s_bvalid), 64'b0100);
    chk("wa_s_bresp", 64'(s_bresp[2]), 64'(SLVERR));
    tick();
    m_bvalid = 1'b0;
    #1;
    chk("wa_idle", 64'(busy), 64'd0);

    // Master 0 writes and reads, master 1 reads: write 0, read 1, read 0
    s_awvalid[0] = 1'b1; s_awaddr[0] = 32'h300;
    s_wvalid[0]  = 1'b1; s_wdata[0]  = 32'h0BADF00D;
    s_arvalid[0] = 1'b1; s_araddr[0] = 32'h304;
    s_arvalid[1] = 1'b1; s_araddr[1] = 32'h308;
    wr_txn(0, 32'h300, 32'h0BADF00D);
    rd_txn(1, 32'h308, 32'h33);
    rd_txn(0, 32'h304, 32'h44);

    // Slave stalls rvalid 10 cycles; master 1 waits
    s_arvalid[0] = 1'b1; s_araddr[0] = 32'h40;
    tick();
    chk("st_grant", 64'(grant_id), 64'd0);
    s_arvalid[1] = 1'b1; s_araddr[1] = 32'h44;
    #1;
    chk("st_s_arready", 64'(s_arready), 64'b0001);
    tick();
    s_arvalid[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("st_wait_arready", 64'(s_arready), 64'd0);
      chk("st_wait_rvalid", 64'(s_rvalid), 64'd0);
      tick();
    end
    m_rvalid = 1'b1; m_rdata = 32'h55;
    #1;
    chk("st_s_rvalid", 64'(s_rvalid), 64'b0001);
    chk("st_arready_hs", 64'(s_arready), 64'd0);
    tick();
    m_rvalid = 1'b0;
    #1;
    chk("st_idle_arready", 64'(s_arready), 64'd0);
    rd_txn(1, 32'h44, 32'h66);

    // Reset during WRESP of master 3
    s_awvalid[3] = 1'b1; s_awaddr[3] = 32'h30;
    s_wvalid[3]  = 1'b1; s_wdata[3]  = 32'hCAFEF00D;
    tick();
    chk("rw_grant", 64'(grant_id), 64'd3);
    tick();
    s_awvalid[3] = 1'b0; s_wvalid[3] = 1'b0;
    m_bvalid = 1'b1;
    #1;
    chk("rw_s_bvalid", 64'(s_bvalid), 64'b1000);
    aresetn = 1'b0;
    #1;
    chk("rw_busy", 64'(busy), 64'd0);
    chk("rw_grant_rst", 64'(grant_id), 64'd0);
    chk("rw_s_bvalid_rst", 64'(s_bvalid), 64'd0);
    chk("rw_m_bready_rst", 64'(m_bready), 64'd0);
    chk("rw_all_rst", 64'({m_awvalid, m_wvalid, m_arvalid, m_rready, s_awready, s_wready, s_arready, s_rvalid}), 64'd0);
    m_bvalid = 1'b0;
    tick();
    aresetn = 1'b1;
    // Pointer restarts at 0: master 1 before master 3
    s_arvalid[1] = 1'b1; s_araddr[1] = 32'h500;
    s_arvalid[3] = 1'b1; s_araddr[3] = 32'h504;
    rd_txn(1, 32'h500, 32'h77);
    rd_txn(3, 32'h504, 32'h88);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
